// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: MEM-stage load/store sequencer driving separate load and store index channels.
// Define LSU_TIMEOUT_EN to add the sticky lsu_timeout watchdog (TIMEOUT_CYCLES).
module lsu_mem_ctrl #(
    parameter int TIMEOUT_CYCLES = 1023
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    input  logic        req_is_load,
    input  logic        req_is_store,
    input  logic        req_is_unsigned,
    input  logic [3:0]  req_ls_size,
    input  logic [63:0] req_addr,
    input  logic [63:0] req_wdata,
    output logic        opload_index_valid,
    output logic [18:0] opload_index,
    input  logic        opload_index_ready,
    input  logic [63:0] opload_read_data,
    input  logic        opload_operation_done,
    output logic        opstore_index_valid,
    output logic [18:0] opstore_index,
    input  logic        opstore_index_ready,
    output logic [63:0] opstore_write_mask,
    output logic [63:0] opstore_write_data,
    input  logic        opstore_operation_done,
    output logic        mem_stall,
    output logic        load_valid,
    output logic [63:0] load_data,
    output logic        lsu_timeout
);
    typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;
    state_t state, state_nx;
    logic accept, sel_ready, sel_done, tmo_hit, unused_bits;
    logic is_ld, is_uns;
    logic [3:0] sz;
    logic [2:0] off, req_off;
    logic [18:0] idx;
    logic [7:0] req_bm;
    logic [63:0] req_mask, wmask, wdat, ld_q, rd_sh, ld_ext;

    // Misaligned addresses are aligned by clearing offset bits below the access size.
    function automatic logic [2:0] align(input logic [2:0] a, input logic [3:0] s);
        return a & {~s[3], ~(s[3] | s[2]), ~(s[3] | s[2] | s[1])};
    endfunction

    assign accept    = (state == IDLE) && req_valid && (req_is_load || req_is_store);
    assign sel_ready = is_ld ? opload_index_ready : opstore_index_ready;
    assign sel_done  = is_ld ? opload_operation_done : opstore_operation_done;
    assign unused_bits = ^{req_addr[63:22], TIMEOUT_CYCLES[0]};

    always_comb begin
        req_off = align(req_addr[2:0], req_ls_size);
        req_bm  = req_ls_size[3] ? 8'hFF : req_ls_size[2] ? 8'h0F : req_ls_size[1] ? 8'h03 : 8'h01;
        req_bm  = req_bm << req_off;
        req_mask = '0;
        for (int i = 0; i < 8; i++) req_mask[8*i +: 8] = {8{req_bm[i]}};
    end

    assign rd_sh  = opload_read_data >> {off, 3'b000};
    assign ld_ext = sz[3] ? rd_sh :
                    sz[2] ? {{32{~is_uns & rd_sh[31]}}, rd_sh[31:0]} :
                    sz[1] ? {{48{~is_uns & rd_sh[15]}}, rd_sh[15:0]} :
                            {{56{~is_uns & rd_sh[7]}}, rd_sh[7:0]};

`ifdef LSU_TIMEOUT_EN
    logic [15:0] cnt;
    logic tmo_q;
    // A real completion in the same cycle wins over the watchdog.
    assign tmo_hit = (state == REQ || (state == WAIT && !sel_done)) &&
                     (({1'b0, cnt} + 17'd1) == 17'(TIMEOUT_CYCLES));
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt   <= '0;
            tmo_q <= 1'b0;
        end else begin
            if (accept) cnt <= '0;
            else if (state == REQ || state == WAIT) cnt <= cnt + 16'd1;
            if (tmo_hit) tmo_q <= 1'b1;
        end
    end
    assign lsu_timeout = tmo_q;
`else
    assign tmo_hit     = 1'b0;
    assign lsu_timeout = 1'b0;
`endif

    always_comb begin
        state_nx = tmo_hit                      ? DONE :
                   accept                       ? REQ  :
                   (state == REQ && sel_ready)  ? WAIT :
                   (state == WAIT && sel_done)  ? DONE :
                   (state == DONE)              ? IDLE : state;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state  <= IDLE;
            is_ld  <= 1'b0;
            is_uns <= 1'b0;
            sz     <= '0;
            off    <= '0;
            idx    <= '0;
            wmask  <= '0;
            wdat   <= '0;
            ld_q   <= '0;
        end else begin
            state <= state_nx;
            if (accept) begin
                is_ld  <= req_is_load;
                is_uns <= req_is_unsigned;
                sz     <= req_ls_size;
                off    <= req_off;
                idx    <= req_addr[21:3];
                wmask  <= req_mask;
                wdat   <= req_wdata << {req_off, 3'b000};
            end
            if (state == WAIT && sel_done && is_ld) ld_q <= ld_ext;
            else if (tmo_hit && is_ld) ld_q <= '0;
        end
    end

    assign opload_index_valid  = (state == REQ) && is_ld;
    assign opstore_index_valid = (state == REQ) && !is_ld;
    assign opload_index        = idx;
    assign opstore_index       = idx;
    assign opstore_write_mask  = wmask;
    assign opstore_write_data  = wdat;
    assign mem_stall           = accept || state == REQ || state == WAIT;
    assign load_valid          = (state == DONE) && is_ld;
    assign load_data           = ld_q;
endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed plus randomized checks of lsu_mem_ctrl against an arithmetic reference.
module tb_lsu_mem_ctrl;
    logic        clock = 1'b0, reset = 1'b1;
    logic        req_valid = 0, req_is_load = 0, req_is_store = 0, req_is_unsigned = 0;
    logic [3:0]  req_ls_size = 0;
    logic [63:0] req_addr = 0, req_wdata = 0;
    logic        opload_index_valid, opload_index_ready = 0, opload_operation_done = 0;
    logic [18:0] opload_index, opstore_index;
    logic [63:0] opload_read_data = 0;
    logic        opstore_index_valid, opstore_index_ready = 0, opstore_operation_done = 0;
    logic [63:0] opstore_write_mask, opstore_write_data;
    logic        mem_stall, load_valid, lsu_timeout;
    logic [63:0] load_data;
    int total = 0, bad = 0;
    logic [63:0] last_ld = 0;

    lsu_mem_ctrl #(.TIMEOUT_CYCLES(8)) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_is_load(req_is_load), .req_is_store(req_is_store),
        .req_is_unsigned(req_is_unsigned), .req_ls_size(req_ls_size),
        .req_addr(req_addr), .req_wdata(req_wdata),
        .opload_index_valid(opload_index_valid), .opload_index(opload_index),
        .opload_index_ready(opload_index_ready), .opload_read_data(opload_read_data),
        .opload_operation_done(opload_operation_done),
        .opstore_index_valid(opstore_index_valid), .opstore_index(opstore_index),
        .opstore_index_ready(opstore_index_ready), .opstore_write_mask(opstore_write_mask),
        .opstore_write_data(opstore_write_data), .opstore_operation_done(opstore_operation_done),
        .mem_stall(mem_stall), .load_valid(load_valid), .load_data(load_data),
        .lsu_timeout(lsu_timeout)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    function automatic logic [63:0] lanes(input int n);
        return (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    endfunction

    task automatic scramble;
        req_valid       = 1'($urandom);
        req_is_load     = 1'($urandom);
        req_is_store    = 1'($urandom);
        req_is_unsigned = 1'($urandom);
        req_ls_size     = 4'($urandom);
        req_addr        = {$urandom, $urandom};
        req_wdata       = {$urandom, $urandom};
    endtask

    // Starts in an IDLE cycle just after a rising edge, ends the same way.
    task automatic op(input logic ld, st, uns, input logic [3:0] sz, input logic [63:0] addr, wd, rd,
                      input int rdly, ddly);
        int n, off;
        logic [63:0] em, ed, el;
        logic [18:0] ei;
        logic sel_ld;
        n   = sz[3] ? 8 : sz[2] ? 4 : sz[1] ? 2 : 1;
        off = int'(addr[2:0]);
        off = off - off % n;
        em  = lanes(n) << (8 * off);
        ed  = wd << (8 * off);
        el  = (rd >> (8 * off)) & lanes(n);
        if (!uns && n < 8 && el[8*n-1]) el = el | ~lanes(n);
        ei  = 19'((addr >> 3) & 64'h7FFFF);
        sel_ld = ld;
        req_valid = 1; req_is_load = ld; req_is_store = st; req_is_unsigned = uns;
        req_ls_size = sz; req_addr = addr; req_wdata = wd;
        @(negedge clock);
        chk("accept_stall", mem_stall, 1);
        tick;
        for (int k = 0; k <= rdly; k++) begin
            scramble();
            opload_index_ready  = sel_ld ? (k == rdly) : 1'($urandom);
            opstore_index_ready = sel_ld ? 1'($urandom) : (k == rdly);
            @(negedge clock);
            chk("req_ld_valid", opload_index_valid, sel_ld);
            chk("req_st_valid", opstore_index_valid, !sel_ld);
            chk("req_index", sel_ld ? opload_index : opstore_index, ei);
            chk("req_stall", mem_stall, 1);
            if (!sel_ld) begin
                chk("req_mask", opstore_write_mask, em);
                chk("req_data", opstore_write_data, ed);
            end
            tick;
        end
        opload_index_ready = 0; opstore_index_ready = 0;
        for (int k = 0; k <= ddly; k++) begin
            scramble();
            opload_operation_done  = sel_ld ? (k == ddly) : 1'($urandom);
            opstore_operation_done = sel_ld ? 1'($urandom) : (k == ddly);
            opload_read_data = (k == ddly) ? rd : {$urandom, $urandom};
            @(negedge clock);
            chk("wait_valids", {opload_index_valid, opstore_index_valid}, 0);
            chk("wait_stall", mem_stall, 1);
            chk("wait_index", sel_ld ? opload_index : opstore_index, ei);
            if (!sel_ld) begin
                chk("wait_mask", opstore_write_mask, em);
                chk("wait_data", opstore_write_data, ed);
            end
            tick;
        end
        opload_operation_done = 0; opstore_operation_done = 0; req_valid = 0;
        @(negedge clock);
        chk("done_stall", mem_stall, 0);
        chk("done_load_valid", load_valid, sel_ld);
        if (sel_ld) last_ld = el;
        chk("done_load_data", load_data, last_ld);
        tick;
        @(negedge clock);
        chk("idle_load_valid", load_valid, 0);
        chk("idle_load_hold", load_data, last_ld);
        tick;
    endtask

    task automatic start_load(input logic [63:0] addr);
        req_valid = 1; req_is_load = 1; req_is_store = 0; req_ls_size = 4'b1000; req_addr = addr;
        @(negedge clock);
        tick;
        req_valid = 0;
    endtask

    initial begin
        tick;
        tick;
        @(negedge clock);
        chk("rst_valids", {opload_index_valid, opstore_index_valid, load_valid, lsu_timeout}, 0);
        chk("rst_outs", {opload_index, opstore_index} | opstore_write_mask | opstore_write_data | load_data, 0);
        chk("rst_stall", mem_stall, 0);
        tick;
        reset = 0;
        req_valid = 1;
        @(negedge clock);
        chk("nonmem_stall", mem_stall, 0);
        tick;
        req_valid = 0;
        @(negedge clock);
        chk("nonmem_ignored", {opload_index_valid, opstore_index_valid}, 0);
        tick;
        op(0, 1, 0, 4'b0100, 64'h1004, 64'h11223344, 0, 0, 0);
        op(1, 0, 0, 4'b0001, 64'h2003, 0, 64'h0000_0000_8000_0000, 0, 0);
        op(1, 0, 1, 4'b0001, 64'h2003, 0, 64'h0000_0000_8000_0000, 0, 0);
        op(1, 0, 0, 4'b1000, 64'h3_FFF8, 0, 64'hDEAD_BEEF_0123_4567, 5, 0);
        op(1, 1, 0, 4'b0010, 64'h77, 64'hFFFF, 64'h8001_0000_0000_0000, 1, 2);
        for (int t = 0; t < 40; t++) begin
            int kind;
            kind = $urandom_range(0, 2);
            op(kind != 1, kind != 0, 1'($urandom), 4'b0001 << $urandom_range(0, 3),
               {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
               $urandom_range(0, 3), $urandom_range(0, 3));
        end
        start_load(64'h4000);
        opload_index_ready = 1;
`ifdef LSU_TIMEOUT_EN
        for (int k = 1; k <= 8; k++) begin
            @(negedge clock);
            chk("tmo_not_yet", lsu_timeout, 0);
            chk("tmo_stall", mem_stall, 1);
            tick;
            opload_index_ready = 0;
        end
        @(negedge clock);
        chk("tmo_rise", lsu_timeout, 1);
        chk("tmo_load_valid", load_valid, 1);
        chk("tmo_load_data", load_data, 0);
        chk("tmo_done_stall", mem_stall, 0);
        tick;
        @(negedge clock);
        chk("tmo_sticky", lsu_timeout, 1);
        chk("tmo_pulse_end", load_valid, 0);
        tick;
`else
        for (int k = 1; k <= 20; k++) begin
            @(negedge clock);
            chk("hang_stall", mem_stall, 1);
            chk("hang_no_tmo", lsu_timeout, 0);
            tick;
            opload_index_ready = 0;
        end
`endif
        start_load(64'h5008);
        opload_index_ready = 1;
        tick;
        opload_index_ready = 0;
        tick;
        reset = 1;
        #1;
        chk("rst_async_stall", mem_stall, 0);
        tick;
        reset = 0;
        opload_operation_done = 1;
        opload_read_data = 64'h1234_5678_9ABC_DEF0;
        @(negedge clock);
        chk("late_done_load_valid", load_valid, 0);
        chk("late_done_stall", mem_stall, 0);
        chk("late_done_valids", {opload_index_valid, opstore_index_valid, lsu_timeout}, 0);
        chk("late_done_outs", {opload_index, opstore_index} | opstore_write_mask | opstore_write_data | load_data, 0);
        tick;
        opload_operation_done = 0;
        @(negedge clock);
        chk("late_done_after", {load_valid, mem_stall}, 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
